// File: rtl/fp_mult_sequencer.sv
// Multi-cycle IEEE-754-style multiplier: shift-add significand loop, normalize, round, pack.
// Define FP_MULT_SPECIALS_EN to classify zero/inf/NaN operands and bypass the datapath.
module fp_mult_sequencer #(
  parameter int unsigned EXPONENT_WIDTH = 8,
  parameter int unsigned MANTISSA_WIDTH = 23,
  parameter int unsigned BIAS           = 127
) (
  input  logic                                 clk_in,
  input  logic                                 reset_in,
  input  logic                                 start_in,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a_in,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b_in,
  output logic                                 ready_out,
  output logic                                 busy_out,
  output logic                                 done_out,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] result_out,
  output logic                                 overflow_out,
  output logic                                 underflow_out
);

  localparam int unsigned E  = EXPONENT_WIDTH;
  localparam int unsigned M  = MANTISSA_WIDTH;
  localparam int unsigned W  = 1 + E + M;
  localparam int unsigned XW = E + 2;
  localparam int unsigned PW = 2 * M + 2;
  localparam int unsigned CW = $clog2(M + 1);
  localparam int unsigned RW = M + 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MULT  = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    op_a, op_b;
  logic            sign_q;
  logic [XW-1:0]   exp_q;
  logic [PW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic [M:0]      field_q;

  logic [M:0]      ma_c, mb_c;
  logic [RW-1:0]   rnd_c;
  logic [M-1:0]    frac_c;
  logic [XW-1:0]   exp_fin_c;
  logic            ovf_c, unf_c;
  logic [W-1:0]    result_c;
  logic            special_c;

  assign ma_c = {1'b1, op_a[M-1:0]};
  assign mb_c = {1'b1, op_b[M-1:0]};

  // Round the normalized field, then saturate or flush on exponent range (two's complement exp).
  always_comb begin
    rnd_c = {1'b0, field_q};
    if (field_q[2:0] >= 3'd5) rnd_c = rnd_c + RW'(1);
    frac_c    = rnd_c[M+1] ? '0 : rnd_c[M:1];
    exp_fin_c = exp_q + XW'(rnd_c[M+1]);
    ovf_c     = !exp_fin_c[XW-1] && (exp_fin_c >= XW'((1 << E) - 1));
    unf_c     = exp_fin_c[XW-1] || (exp_fin_c == '0);
    result_c  = {sign_q, exp_fin_c[E-1:0], frac_c};
    if (ovf_c)      result_c = {sign_q, {E{1'b1}}, {M{1'b0}}};
    else if (unf_c) result_c = {sign_q, {E{1'b0}}, {M{1'b0}}};
  end

`ifdef FP_MULT_SPECIALS_EN
  logic         a_zero_c, a_inf_c, a_nan_c, b_zero_c, b_inf_c, b_nan_c;
  logic [W-1:0] spec_result_c;

  // Operand classification and the bypass result for non-finite / zero inputs.
  always_comb begin
    a_zero_c = (op_a[W-2:M] == '0);
    b_zero_c = (op_b[W-2:M] == '0);
    a_inf_c  = (op_a[W-2:M] == '1) && (op_a[M-1:0] == '0);
    b_inf_c  = (op_b[W-2:M] == '1) && (op_b[M-1:0] == '0);
    a_nan_c  = (op_a[W-2:M] == '1) && (op_a[M-1:0] != '0);
    b_nan_c  = (op_b[W-2:M] == '1) && (op_b[M-1:0] != '0);
    special_c = a_zero_c || b_zero_c || a_inf_c || b_inf_c || a_nan_c || b_nan_c;
    spec_result_c = {op_a[W-1] ^ op_b[W-1], {E{1'b0}}, {M{1'b0}}};
    if (a_nan_c || b_nan_c || (a_inf_c && b_zero_c) || (b_inf_c && a_zero_c))
      spec_result_c = {1'b0, {E{1'b1}}, M'(1) << (M - 1)};
    else if (a_inf_c || b_inf_c)
      spec_result_c = {op_a[W-1] ^ op_b[W-1], {E{1'b1}}, {M{1'b0}}};
  end
`else
  assign special_c = 1'b0;
`endif

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_in) state_d = LOAD;
      LOAD:    state_d = special_c ? DONE : MULT;
      MULT:    if (cnt_q == CW'(M)) state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      op_a          <= '0;
      op_b          <= '0;
      sign_q        <= 1'b0;
      exp_q         <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      field_q       <= '0;
      result_out    <= '0;
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
      done_out      <= 1'b0;
      busy_out      <= 1'b0;
      ready_out     <= 1'b1;
    end else begin
      ready_out <= (state_d == IDLE);
      busy_out  <= (state_d != IDLE);
      done_out  <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (start_in) begin
            op_a          <= a_in;
            op_b          <= b_in;
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
          end
        end
        LOAD: begin
          sign_q <= op_a[W-1] ^ op_b[W-1];
          exp_q  <= XW'(op_a[W-2:M]) + XW'(op_b[W-2:M]) - XW'(BIAS);
          acc_q  <= '0;
          cnt_q  <= '0;
`ifdef FP_MULT_SPECIALS_EN
          if (special_c) result_out <= spec_result_c;
`endif
        end
        MULT: begin
          if (ma_c[cnt_q]) acc_q <= acc_q + (PW'(mb_c) << cnt_q);
          cnt_q <= cnt_q + CW'(1);
        end
        NORM: begin
          if (acc_q[PW-1]) begin
            field_q <= acc_q[PW-2:M];
            exp_q   <= exp_q + XW'(1);
          end else begin
            field_q <= acc_q[PW-3:M-1];
          end
        end
        ROUND: begin
          result_out    <= result_c;
          overflow_out  <= ovf_c;
          underflow_out <= unf_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mult_sequencer.sv
// Self-checking bench for fp_mult_sequencer: vector table, corner sequences and random ops vs a model.
module tb_fp_mult_sequencer;

  localparam int LAT_FULL = 27;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic        start_in = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        ready_out, busy_out, done_out, overflow_out, underflow_out;
  logic [31:0] result_out;

  int errors = 0;
  int checks = 0;

  fp_mult_sequencer dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .start_in     (start_in),
    .a_in         (a_in),
    .b_in         (b_in),
    .ready_out    (ready_out),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .result_out   (result_out),
    .overflow_out (overflow_out),
    .underflow_out(underflow_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        special;
  } ref_t;

  // Reference: full-width integer product, then the normalize/round/range rules in plain arithmetic.
  function automatic ref_t ref_mult(input logic [31:0] a, input logic [31:0] b);
    ref_t              r;
    longint unsigned   p, field, frac;
    int                ex;
    logic              sgn;
`ifdef FP_MULT_SPECIALS_EN
    logic az, bz, ai, bi, an, bn;
`endif
    sgn = a[31] ^ b[31];
    r.ovf = 1'b0;
    r.unf = 1'b0;
    r.special = 1'b0;
`ifdef FP_MULT_SPECIALS_EN
    az = (a[30:23] == 8'h00);
    bz = (b[30:23] == 8'h00);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    an = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    if (an || bn || az || bz || ai || bi) begin
      r.special = 1'b1;
      if (an || bn || (ai && bz) || (bi && az)) r.res = 32'h7FC00000;
      else if (ai || bi)                        r.res = {sgn, 8'hFF, 23'h0};
      else                                      r.res = {sgn, 31'h0};
      return r;
    end
`endif
    p  = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
    ex = int'(a[30:23]) + int'(b[30:23]) - 127;
    if ((p >> 47) != 0) begin
      field = (p >> 23) & 64'hFFFFFF;
      ex++;
    end else begin
      field = (p >> 22) & 64'hFFFFFF;
    end
    if ((field % 8) >= 5) field++;
    if (field == 64'h1000000) begin
      frac = 0;
      ex++;
    end else begin
      frac = field >> 1;
    end
    if (ex >= 255) begin
      r.res = {sgn, 8'hFF, 23'h0};
      r.ovf = 1'b1;
    end else if (ex <= 0) begin
      r.res = {sgn, 31'h0};
      r.unf = 1'b1;
    end else begin
      r.res = {sgn, 8'(ex), 23'(frac)};
    end
    return r;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!ready_out && n < 100) begin
      @(posedge clk_in); #1;
      n++;
    end
    if (!ready_out) check("ready_timeout", 64'(ready_out), 64'd1);
  endtask

  // Present operands with start_in over one accepting edge; returns #1 after that edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit hold);
    wait_ready();
    @(negedge clk_in);
    start_in = 1'b1;
    a_in = a;
    b_in = b;
    @(posedge clk_in); #1;
    if (!hold) start_in = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done_out && cycles < 100) begin
      @(posedge clk_in); #1;
      cycles++;
    end
  endtask

  task automatic check_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic eo, input logic eu, input int elat);
    int c;
    start_op(a, b, 1'b0);
    wait_done(c);
    check({tag, "_latency"}, 64'(c), 64'(elat));
    check({tag, "_result"}, 64'(result_out), 64'(er));
    check({tag, "_ovf"}, 64'(overflow_out), 64'(eo));
    check({tag, "_unf"}, 64'(underflow_out), 64'(eu));
    check({tag, "_ready_in_done"}, 64'(ready_out), 64'd0);
    @(posedge clk_in); #1;
    check({tag, "_done_pulse"}, 64'(done_out), 64'd0);
    check({tag, "_result_held"}, 64'(result_out), 64'(er));
  endtask

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string n, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic o, input logic u, input int l);
    vec_t v;
    v.name = n; v.a = a; v.b = b; v.res = r; v.ovf = o; v.unf = u; v.lat = l;
    vecs.push_back(v);
  endtask

  initial begin
    int   c, seen;
    ref_t r;
    logic [31:0] ra, rb;

    add_vec("v_1p5x2",   32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, LAT_FULL);
    add_vec("v_round",   32'h3FFFFFFF, 32'h3F800000, 32'h3FFFFFFF, 1'b0, 1'b0, LAT_FULL);
    add_vec("v_ovf",     32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0, LAT_FULL);
    add_vec("v_unf",     32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, LAT_FULL);
    add_vec("v_neg1",    32'hBF800000, 32'h3F800000, 32'hBF800000, 1'b0, 1'b0, LAT_FULL);
    add_vec("v_2x2",     32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0, LAT_FULL);
`ifdef FP_MULT_SPECIALS_EN
    add_vec("v_zero",    32'h00000000, 32'hC0000000, 32'h80000000, 1'b0, 1'b0, 1);
    add_vec("v_infx0",   32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0, 1);
    add_vec("v_ninf",    32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0, 1);
    add_vec("v_nan",     32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0, 1);
`else
    add_vec("v_noclass", 32'h7F800000, 32'h00000000, 32'h40000000, 1'b0, 1'b0, LAT_FULL);
`endif

    // Reset values while reset is held.
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_ready", 64'(ready_out), 64'd1);
    check("rst_busy", 64'(busy_out), 64'd0);
    check("rst_done", 64'(done_out), 64'd0);
    check("rst_result", 64'(result_out), 64'd0);
    check("rst_flags", 64'({overflow_out, underflow_out}), 64'd0);
    @(negedge clk_in);
    reset_in = 1'b0;

    foreach (vecs[i])
      check_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf, vecs[i].unf, vecs[i].lat);

    // Async reset in the middle of the multiply loop.
    check_op("pre_rst", 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0, LAT_FULL);
    start_op(32'h3FC00000, 32'h40000000, 1'b0);
    repeat (6) @(posedge clk_in);
    #2;
    reset_in = 1'b1;
    #1;
    check("midrst_ready", 64'(ready_out), 64'd1);
    check("midrst_busy", 64'(busy_out), 64'd0);
    check("midrst_done", 64'(done_out), 64'd0);
    check("midrst_result", 64'(result_out), 64'd0);
    check("midrst_flags", 64'({overflow_out, underflow_out}), 64'd0);
    @(negedge clk_in);
    reset_in = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk_in); #1;
      if (done_out || busy_out) seen++;
    end
    check("midrst_no_done", 64'(seen), 64'd0);
    check_op("post_rst", 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, LAT_FULL);

    // start_in held with new operands while busy: ignored until the IDLE cycle after DONE.
    start_op(32'h3FC00000, 32'h40000000, 1'b1);
    a_in = 32'h40000000;
    b_in = 32'h40000000;
    wait_done(c);
    check("b2b_first_lat", 64'(c), 64'(LAT_FULL));
    check("b2b_first_res", 64'(result_out), 64'h40400000);
    @(posedge clk_in); #1;
    check("b2b_idle_ready", 64'(ready_out), 64'd1);
    @(posedge clk_in); #1;
    check("b2b_accept_busy", 64'(busy_out), 64'd1);
    start_in = 1'b0;
    wait_done(c);
    check("b2b_second_lat", 64'(c), 64'(LAT_FULL));
    check("b2b_second_res", 64'(result_out), 64'h40800000);
    @(posedge clk_in); #1;

    // Random operands against the reference model.
    for (int k = 0; k < 40; k++) begin
      ra = $urandom;
      rb = $urandom;
      if (k % 4 == 0) ra[30:23] = 8'(7'h40 + $urandom_range(0, 63));
      r = ref_mult(ra, rb);
      check_op($sformatf("rnd%0d_%08h_%08h", k, ra, rb), ra, rb, r.res, r.ovf, r.unf,
               r.special ? 1 : LAT_FULL);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
